bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Parametrised digit-serial BCD adder/subtractor for N-digit decimal operands. It generalises the fixed two-digit combinational BCD adder to DIGITS digits and adds subtract mode, input-digit validation and a start/busy/done handshake. One digit is processed per clock, least-significant digit first, through a single shared digit adder. It sits between operand registers and the decimal display/result logic of the calculator datapath.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1..16.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- busy  output  1  high while digits are being processed (ADD state).
- done  output  1  one-cycle pulse, result valid.
- sum  output  4*DIGITS  packed BCD result, held until the next accepted start.
- carry  output  1  add: decimal carry out; sub: 1 = no borrow (a ≥ b).
- invalid  output  1  some digit of a or b was > 9 at start.

## Operation
- States: IDLE, ADD, DONE.
- IDLE: start=1 → latch a; latch b, or its nines complement (9−digit per digit) when sub=1; set carry-in = sub; set digit index = 0; evaluate invalid across all 2*DIGITS input digits; go to ADD.
- ADD: each cycle, digit i: s = ai + bi + cin (5 bits); if s > 9, then digit = s+6 (low 4 bits) and cout = 1, else digit = s and cout = 0. Digit shifts into the internal result register. Index increments. At index DIGITS−1, go to DONE.
- DONE: sum, carry and invalid update together on entry. done=1 for exactly one cycle, then return to IDLE.
- Subtract with a < b: sum = ten's complement (10^DIGITS + a − b), carry=0.
- invalid=1: sum forced to all zeros, carry=0. The handshake timing is unchanged.
- start while in ADD or DONE is ignored; no queuing.
- a, b and sub may change after the start edge without affecting the result.

## Timing
- Start accepted at edge E0. busy=1 from E0 through edge E_DIGITS. done=1 and outputs valid after E_DIGITS. done clears at E_DIGITS+1.
- Latency is DIGITS+1 edges start-to-done; throughput is one operation per DIGITS+2 cycles. start held high in DONE is not accepted until back in IDLE.
- Reset values: state IDLE, busy=0, done=0, sum=0, carry=0, invalid=0, internal registers 0.
- rst_n low mid-operation aborts immediately to reset values. No done is issued for the aborted operation.
- DIGITS=1: a single ADD cycle, same state sequence.

## Structure
- Shared package bcd_pkg: state typedef (IDLE/ADD/DONE), constant BCD_MAX=9, constant BCD_CORR=6, nines-complement function.
- Sub-module bcd_digit_add: combinational, inputs a[3:0], b[3:0], cin; outputs s[3:0], cout. Instantiated once.
- Top level holds the FSM, index counter (width $clog2(DIGITS+1)), operand shift registers and the result register.

## Test plan
- DIGITS=4, add 0002+0005 → after 5 edges: done pulse, sum=0007, carry=0, invalid=0.
- Add 0017+0093 → sum=0110, carry=0. Add 9999+0001 → sum=0000, carry=1 (carry ripple through all digits).
- Sub 0050−0017 → sum=0033, carry=1. Sub 0017−0050 → sum=9967, carry=0.
- a=00A3 (digit 1 = 0xA), add 0001 → invalid=1, sum=0000, carry=0, done still at E4.
- start pulsed again during ADD, and operands changed after E0 → ignored; result matches the originally latched operands. Exactly one done pulse.
- rst_n asserted at E2 of an operation → all outputs 0 asynchronously, no done. A new start after release gives a correct result. Also rerun 9999+9999 with DIGITS=1 and DIGITS=8 (→ sum=9…98, carry=1).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types, BCD constants and helpers for the digit-serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic [3:0] nines(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with carry in/out; the one shared arithmetic unit.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  always_comb begin
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      s    = raw[3:0] + BCD_CORR;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, through a
// single bcd_digit_add, with a start/busy/done handshake.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);

  state_t             state_reg, state_next;
  logic [W-1:0]       a_reg, b_reg, res_reg, res_full, sum_reg;
  logic [W-1:0]       b_conv;
  logic [IDX_W-1:0]   idx_reg;
  logic               cin_reg, inv_reg, carry_reg, invalid_reg;
  logic               in_bad, last;
  logic [3:0]         digit;
  logic               cout;

  // Subtraction is a + nines(b) + 1, so the final carry doubles as "no borrow".
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_conv
      assign b_conv[4*gi +: 4] = sub ? nines(b[4*gi +: 4]) : b[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) in_bad = 1'b1;
    end
  end

  bcd_digit_add u_digit (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (cin_reg),
    .s    (digit),
    .cout (cout)
  );

  assign last = (idx_reg == IDX_W'(DIGITS - 1));

  always_comb begin
    res_full = res_reg;
    res_full[4*idx_reg +: 4] = digit;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      idx_reg     <= '0;
      cin_reg     <= 1'b0;
      inv_reg     <= 1'b0;
      sum_reg     <= '0;
      carry_reg   <= 1'b0;
      invalid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b_conv;
            cin_reg <= sub;
            idx_reg <= '0;
            res_reg <= '0;
            inv_reg <= in_bad;
          end
        end
        ADD: begin
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          cin_reg <= cout;
          idx_reg <= idx_reg + 1'b1;
          res_reg <= res_full;
          if (last) begin
            sum_reg     <= inv_reg ? '0 : res_full;
            carry_reg   <= cout & ~inv_reg;
            invalid_reg <= inv_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_reg == ADD);
  assign done    = (state_reg == DONE);
  assign sum     = sum_reg;
  assign carry   = carry_reg;
  assign invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder at DIGITS=4, 1 and 8 against an integer-arithmetic model.
module tb_bcd_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start_v, sub_v;
  logic [63:0] a_bus [3];
  logic [63:0] b_bus [3];
  logic [2:0]  busy_v, done_v, carry_v, inv_v;
  logic [15:0] sum4;
  logic [3:0]  sum1;
  logic [31:0] sum8;

  int total = 0;
  int bad   = 0;
  int dw [3] = '{4, 1, 8};

  bcd_serial_adder #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_bus[0][15:0]), .b(b_bus[0][15:0]), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum4), .carry(carry_v[0]), .invalid(inv_v[0]));

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_bus[1][3:0]), .b(b_bus[1][3:0]), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum1), .carry(carry_v[1]), .invalid(inv_v[1]));

  bcd_serial_adder #(.DIGITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
    .a(a_bus[2][31:0]), .b(b_bus[2][31:0]), .busy(busy_v[2]), .done(done_v[2]),
    .sum(sum8), .carry(carry_v[2]), .invalid(inv_v[2]));

  function automatic logic [63:0] get_sum(input int u);
    case (u)
      0:       return {48'd0, sum4};
      1:       return {60'd0, sum1};
      default: return {32'd0, sum8};
    endcase
  endfunction

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic longint bcd2int(input logic [63:0] v, input int nd);
    longint r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] int2bcd(input longint v, input int nd);
    logic [63:0] r = '0;
    longint t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [63:0] v, input int nd);
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Decimal arithmetic on whole numbers, then reduced modulo 10^nd.
  task automatic model(input logic [63:0] av, input logic [63:0] bv, input logic sv,
                       input int nd, output logic [63:0] es, output logic ec,
                       output logic ei);
    longint la, lb, p, r;
    la = bcd2int(av, nd);
    lb = bcd2int(bv, nd);
    p  = pow10(nd);
    ei = has_bad(av, nd) | has_bad(bv, nd);
    if (ei) begin
      es = '0;
      ec = 1'b0;
    end else if (sv) begin
      r  = la - lb;
      ec = (r >= 0);
      es = int2bcd((r >= 0) ? r : p + r, nd);
    end else begin
      r  = la + lb;
      ec = (r >= p);
      es = int2bcd(r % p, nd);
    end
  endtask

  function automatic logic [63:0] rand_bcd(input int nd);
    longint v = longint'($urandom_range(32'(pow10(nd) - 1), 0));
    return int2bcd(v, nd);
  endfunction

  task automatic check_outputs(input int u, input string tag, input logic [63:0] es,
                               input logic ec, input logic ei);
    total++;
    if (get_sum(u) !== es || carry_v[u] !== ec || inv_v[u] !== ei) begin
      bad++;
      $display("FAIL %s result: got sum=%h carry=%b inv=%b want sum=%h carry=%b inv=%b",
               tag, get_sum(u), carry_v[u], inv_v[u], es, ec, ei);
    end
  endtask

  task automatic run_op(input int u, input logic [63:0] av, input logic [63:0] bv,
                        input logic sv, input bit disturb, input string tag);
    int nd;
    logic [63:0] es;
    logic ec, ei;
    nd = dw[u];
    model(av, bv, sv, nd, es, ec, ei);
    @(negedge clk);
    a_bus[u] = av; b_bus[u] = bv; sub_v[u] = sv; start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    total++;
    if (busy_v[u] !== 1'b1 || done_v[u] !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: got busy=%b done=%b want busy=1 done=0", tag, busy_v[u], done_v[u]);
    end
    if (disturb) begin
      a_bus[u] = {$urandom, $urandom}; b_bus[u] = {$urandom, $urandom}; sub_v[u] = ~sv;
    end
    for (int k = 1; k <= nd; k++) begin
      @(posedge clk); #1;
      if (disturb) start_v[u] = (k == 1);
      if (k < nd) begin
        total++;
        if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b1) begin
          bad++;
          $display("FAIL %s edge%0d: got busy=%b done=%b want busy=1 done=0",
                   tag, k, busy_v[u], done_v[u]);
        end
      end else begin
        total++;
        if (done_v[u] !== 1'b1 || busy_v[u] !== 1'b0) begin
          bad++;
          $display("FAIL %s done_edge: got busy=%b done=%b want busy=0 done=1",
                   tag, busy_v[u], done_v[u]);
        end
        check_outputs(u, tag, es, ec, ei);
      end
    end
    start_v[u] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b0 || get_sum(u) !== es) begin
      bad++;
      $display("FAIL %s after_done: got done=%b busy=%b sum=%h want done=0 busy=0 sum=%h",
               tag, done_v[u], busy_v[u], get_sum(u), es);
    end
    $display("op %s D=%0d a=%h b=%h sub=%b -> sum=%h carry=%b inv=%b", tag, nd,
             av, bv, sv, get_sum(u), carry_v[u], inv_v[u]);
  endtask

  task automatic check_zero(input string tag);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (get_sum(u) !== 64'd0 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 ||
          carry_v[u] !== 1'b0 || inv_v[u] !== 1'b0) begin
        bad++;
        $display("FAIL %s u%0d: got sum=%h busy=%b done=%b carry=%b inv=%b want all 0",
                 tag, u, get_sum(u), busy_v[u], done_v[u], carry_v[u], inv_v[u]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_add();
    run_op(0, 64'h0002, 64'h0005, 1'b0, 1'b0, "add_2_5");
    run_op(0, 64'h0017, 64'h0093, 1'b0, 1'b0, "add_17_93");
    run_op(0, 64'h9999, 64'h0001, 1'b0, 1'b0, "add_ripple");
    run_op(0, 64'h9999, 64'h9999, 1'b0, 1'b0, "add_max");
    for (int i = 0; i < 6; i++) run_op(0, rand_bcd(4), rand_bcd(4), 1'b0, 1'b0, "add_rand");
  endtask

  task automatic test_sub();
    logic [63:0] x;
    run_op(0, 64'h0050, 64'h0017, 1'b1, 1'b0, "sub_50_17");
    run_op(0, 64'h0017, 64'h0050, 1'b1, 1'b0, "sub_17_50");
    run_op(0, 64'h0000, 64'h0001, 1'b1, 1'b0, "sub_0_1");
    x = rand_bcd(4);
    run_op(0, x, x, 1'b1, 1'b0, "sub_equal");
    for (int i = 0; i < 6; i++) run_op(0, rand_bcd(4), rand_bcd(4), 1'b1, 1'b0, "sub_rand");
  endtask

  task automatic test_invalid();
    logic [63:0] x;
    run_op(0, 64'h00A3, 64'h0001, 1'b0, 1'b0, "inv_a");
    for (int i = 0; i < 3; i++) begin
      x = rand_bcd(4);
      x[4*$urandom_range(3, 0) +: 4] = 4'($urandom_range(15, 10));
      run_op(0, rand_bcd(4), x, 1'($urandom_range(1, 0)), 1'b0, "inv_b");
    end
  endtask

  task automatic test_disturb();
    run_op(0, 64'h1234, 64'h0987, 1'b0, 1'b1, "disturb_add");
    run_op(0, 64'h0100, 64'h0999, 1'b1, 1'b1, "disturb_sub");
  endtask

  task automatic test_abort();
    @(negedge clk);
    a_bus[0] = 64'h9999; b_bus[0] = 64'h0001; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      total++;
      if (done_v[0] !== 1'b0) begin
        bad++;
        $display("FAIL abort_nodone cyc%0d: got done=%b want 0", k, done_v[0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("abort checked");
    run_op(0, 64'h0456, 64'h0789, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [63:0] es, a2, b2;
    logic ec, ei;
    @(negedge clk);
    a_bus[0] = 64'h0808; b_bus[0] = 64'h0303; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    model(64'h0808, 64'h0303, 1'b0, 4, es, ec, ei);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin @(posedge clk); #1; end
    total++;
    if (done_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done1: got done=%b want 1", done_v[0]);
    end
    check_outputs(0, "b2b_first", es, ec, ei);
    @(posedge clk); #1;
    total++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy_v[0], done_v[0]);
    end
    a2 = rand_bcd(4); b2 = rand_bcd(4);
    a_bus[0] = a2; b_bus[0] = b2; sub_v[0] = 1'b1;
    model(a2, b2, 1'b1, 4, es, ec, ei);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    total++;
    if (busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept2: got busy=%b want 1", busy_v[0]);
    end
    for (int k = 1; k <= 4; k++) begin @(posedge clk); #1; end
    total++;
    if (done_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done2: got done=%b want 1", done_v[0]);
    end
    check_outputs(0, "b2b_second", es, ec, ei);
    $display("op b2b second a=%h b=%h sub=1 -> sum=%h carry=%b", a2, b2, sum4, carry_v[0]);
  endtask

  task automatic test_widths();
    run_op(1, 64'h9, 64'h9, 1'b0, 1'b0, "d1_max");
    run_op(1, 64'h3, 64'h7, 1'b1, 1'b0, "d1_sub");
    run_op(1, 64'hB, 64'h1, 1'b0, 1'b0, "d1_inv");
    for (int i = 0; i < 3; i++)
      run_op(1, rand_bcd(1), rand_bcd(1), 1'($urandom_range(1, 0)), 1'b0, "d1_rand");
    run_op(2, 64'h99999999, 64'h99999999, 1'b0, 1'b0, "d8_max");
    for (int i = 0; i < 4; i++)
      run_op(2, rand_bcd(8), rand_bcd(8), 1'($urandom_range(1, 0)), 1'b0, "d8_rand");
  endtask

  initial begin
    start_v = '0;
    sub_v   = '0;
    for (int u = 0; u < 3; u++) begin
      a_bus[u] = '0;
      b_bus[u] = '0;
    end
    test_reset();
    test_add();
    test_sub();
    test_invalid();
    test_disturb();
    test_abort();
    test_back_to_back();
    test_widths();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
